tick_gen: RTL

Programmable enable-pulse generator that sits directly upstream of the 4-bit counter and drives its `en` input.
- Divides `clk` by a programmable ratio to produce single-cycle `tick` pulses.
- Modes: continuous (free-running until stopped) or burst (emits exactly N ticks, then stops and flags done).
- Lets benches and system logic pace the counter without gating the clock.

---
 rtl/tick_gen_pkg.sv | 14 +
 rtl/tick_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the tick generator.
package tick_gen_pkg;

    // Generator state; mode_q selects whether RUN counts down a burst.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Run modes, latched at start.
    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Programmable enable-pulse generator: divides clk by (div+1) and emits
// single-cycle tick pulses, either free-running or as a fixed-length burst.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] burst_len,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    // One extra bit so a burst length of 0 can stand for 2^LEN_W.
    localparam int unsigned REM_W = LEN_W + 1;
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(1) << LEN_W;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               mode_q, mode_d;
    logic [DIV_W-1:0]   prescale_q, prescale_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mode_d      = mode_q;
        prescale_d  = prescale_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RUN;
                    div_d       = div;
                    mode_d      = mode;
                    prescale_d  = '0;
                    remaining_d = (burst_len == '0) ? REM_FULL : {1'b0, burst_len};
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort wins over a tick that would fall on this edge.
                    state_d    = IDLE;
                    prescale_d = '0;
                end else if (prescale_q == div_q) begin
                    prescale_d = '0;
                    tick_d     = 1'b1;
                    busy_d     = 1'b1;
                    if (mode_q == MODE_BURST) begin
                        remaining_d = remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            // Final tick: busy stays high alongside done for
                            // this one cycle, then drops.
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    prescale_d = prescale_q + DIV_W'(1);
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            mode_q      <= MODE_CONT;
            prescale_q  <= '0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            prescale_q  <= prescale_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tick = tick_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
